// File: rtl/contador_16.sv
// contador_16: 4-bit up/down counter with count enable and asynchronous
// active-low reset. The count register drives contagem_out directly.
// Optional build macro: CONTADOR_16_ASSERTIONS_EN adds concurrent assertions
// that check hold, increment, decrement and output definedness while out of reset.
module contador_16 #(
    parameter int unsigned           WIDTH       = 4,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dir_cont,
    input  logic             enable_contador,
    output logic [WIDTH-1:0] contagem_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: hold unless enabled; direction selects +1 or -1, wrapping naturally
    always_comb begin
        count_d = count_q;
        if (enable_contador) begin
            if (dir_cont) begin
                count_d = count_q - ONE;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Count register; reset wins over everything and is independent of clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign contagem_out = count_q;

`ifdef CONTADOR_16_ASSERTIONS_EN
    // Disabled counter keeps its value
    property p_hold;
        @(posedge clk) disable iff (!reset)
            !enable_contador |=> (contagem_out == $past(contagem_out));
    endproperty
    a_hold: assert property (p_hold);

    // Enabled up-count advances by one, modulo 2**WIDTH
    property p_up;
        @(posedge clk) disable iff (!reset)
            (enable_contador && !dir_cont) |=>
                (contagem_out == WIDTH'($past(contagem_out) + ONE));
    endproperty
    a_up: assert property (p_up);

    // Enabled down-count retreats by one, modulo 2**WIDTH
    property p_down;
        @(posedge clk) disable iff (!reset)
            (enable_contador && dir_cont) |=>
                (contagem_out == WIDTH'($past(contagem_out) - ONE));
    endproperty
    a_down: assert property (p_down);

    // Output is always a defined value once out of reset
    property p_known;
        @(posedge clk) disable iff (!reset)
            !$isunknown(contagem_out);
    endproperty
    a_known: assert property (p_known);
`endif

endmodule

// File: tb/tb_contador_16.sv
// Bench for contador_16: a reference model computes each expected count when
// stimulus is driven, pushes it to a queue, and each scenario task pops and
// compares after the edge that should produce it.
module tb_contador_16;

    logic       clk;
    logic       reset;
    logic       dir_cont;
    logic       enable_contador;
    logic [3:0] contagem_out;

    int errors = 0;
    int checks = 0;

    logic [3:0] model_count;
    logic [3:0] exp_q[$];

    contador_16 #(
        .WIDTH       (4),
        .RESET_VALUE (4'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dir_cont        (dir_cont),
        .enable_contador (enable_contador),
        .contagem_out    (contagem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: explicit wrap cases, independent of modular arithmetic
    function automatic logic [3:0] model_next(input logic [3:0] cur, input logic en, input logic dir);
        if (!en)                  return cur;
        else if (!dir && cur == 4'hF) return 4'h0;
        else if (!dir)            return cur + 4'h1;
        else if (cur == 4'h0)     return 4'hF;
        else                      return cur - 4'h1;
    endfunction

    // Drive one cycle of stimulus at the falling edge, push expectation, settle after rising edge
    task automatic drive_edge(input logic en, input logic dir);
        @(negedge clk);
        enable_contador = en;
        dir_cont        = dir;
        model_count     = model_next(model_count, en, dir);
        exp_q.push_back(model_count);
        @(posedge clk);
        #1;
    endtask

    // Power-up reset, reset ignores clock edges, then clean release
    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b0; enable_contador = 1'b0; dir_cont = 1'b0;
        #12;
        got = contagem_out; checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL reset_initial: got %h expected 0", got); end
        enable_contador = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            got = contagem_out; checks++;
            if (got !== 4'h0) begin errors++; $display("FAIL reset_hold[%0d]: got %h expected 0", i, got); end
        end
        @(negedge clk);
        enable_contador = 1'b0;
        reset = 1'b1;
        model_count = 4'h0;
    endtask

    // Mid-cycle reset pulse of 10 ns spanning one rising edge; checks are done by callers
    task automatic reset_pulse_start();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic reset_pulse_end();
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_up();
        logic [3:0] got, exp;
        for (int i = 0; i < 20; i++) begin
            drive_edge(1'b1, 1'b0);
            got = contagem_out; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL count_up[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_hold();
        logic [3:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 1'(i % 2));
            got = contagem_out; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL hold[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] got, exp;
        reset_pulse_start();
        got = contagem_out; checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL down_reset_async: got %h expected 0", got); end
        reset_pulse_end();
        got = contagem_out; checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL down_reset_edge: got %h expected 0", got); end
        #1 reset = 1'b1;
        model_count = 4'h0;
        for (int i = 0; i < 20; i++) begin
            drive_edge(1'b1, 1'b1);
            got = contagem_out; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL count_down[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    // Direction changes at value 7 (up->down) and at 8 heading down to 7 (down->up)
    task automatic test_dir_toggle();
        logic [3:0] got, exp;
        logic       dirs[12];
        dirs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        reset_pulse_start();
        reset_pulse_end();
        #1 reset = 1'b1;
        model_count = 4'h0;
        for (int i = 0; i < 12; i++) begin
            drive_edge(1'b1, dirs[i]);
            got = contagem_out; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL dir_toggle[%0d]: got %h expected %h", i, got, exp); end
        end
        checks++;
        if (contagem_out !== 4'h8) begin errors++; $display("FAIL dir_toggle_final: got %h expected 8", contagem_out); end
    endtask

    // Reset during counting at A aborts immediately; count restarts from 0
    task automatic test_reset_mid_count();
        logic [3:0] got, exp;
        for (int i = 0; i < 2; i++) begin
            drive_edge(1'b1, 1'b0);
            void'(exp_q.pop_front());
        end
        checks++;
        if (contagem_out !== 4'hA) begin errors++; $display("FAIL mid_reach_A: got %h expected a", contagem_out); end
        reset_pulse_start();
        got = contagem_out; checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL mid_reset_async: got %h expected 0", got); end
        reset_pulse_end();
        got = contagem_out; checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL mid_reset_edge: got %h expected 0", got); end
        #1 reset = 1'b1;
        model_count = 4'h0;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 1'b0);
            got = contagem_out; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL mid_restart[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    // Random enable/direction mix, every cycle back to back
    task automatic test_back_to_back();
        logic [3:0] got, exp;
        for (int i = 0; i < 40; i++) begin
            drive_edge(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            got = contagem_out; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    initial begin
        model_count = 4'h0;
        test_reset();
        test_count_up();
        test_hold();
        test_count_down();
        test_dir_toggle();
        test_reset_mid_count();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/contador_16.md
CONTADOR_16 -- requirements
Module: contador_16

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; only 4 is required to be supported.
REQ-002 Parameter RESET_VALUE, default 4'h0, value loaded into the count on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 dir_cont  input  1  count direction: 0 = up (increment), 1 = down (decrement).
REQ-006 enable_contador  input  1  count enable: 1 = count, 0 = hold.
REQ-007 contagem_out  output  WIDTH  current count, driven directly from the count register.
REQ-008 Port order SHALL be clk, reset, dir_cont, enable_contador, contagem_out so that positional instantiation works.

Function
REQ-009 On each rising clk edge with reset=1 and enable_contador=1 and dir_cont=0, contagem_out SHALL become (contagem_out + 1) mod 16.
REQ-010 On each rising clk edge with reset=1 and enable_contador=1 and dir_cont=1, contagem_out SHALL become (contagem_out - 1) mod 16.
REQ-011 Up-count wrap-around: 4'hF SHALL be followed by 4'h0 with no extra cycle and no hold.
REQ-012 Down-count wrap-around: 4'h0 SHALL be followed by 4'hF with no extra cycle and no hold.
REQ-013 With enable_contador=0, contagem_out SHALL hold its value on every edge, regardless of dir_cont.
REQ-014 Latency: one clock; a value sampled on edge N SHALL be visible on contagem_out after edge N, with no combinational path from inputs to output.
REQ-015 A dir_cont change SHALL take effect on the first rising edge that samples it; there is no pipeline and no turnaround cycle.
REQ-016 Priority is reset > enable_contador > dir_cont.
REQ-017 The block SHALL have no other state; the count register is the only sequential element.

Reset
REQ-018 reset=0 SHALL force contagem_out to RESET_VALUE (4'h0) immediately, independent of clk.
REQ-019 While reset=0, the count SHALL stay at RESET_VALUE and all clock edges SHALL be ignored.
REQ-020 Reset asserted mid-count (either direction) SHALL abort the count.
REQ-021 After reset is released, counting SHALL resume from RESET_VALUE on the first rising edge with enable_contador=1.
REQ-022 Release of reset is expected to be synchronous to clk, driven away from the rising edge.

Configuration
REQ-023 Macro CONTADOR_16_ASSERTIONS_EN: when defined, the block SHALL include concurrent assertions, active only when reset=1.
REQ-024 The assertions SHALL check: (a) output unchanged when enable_contador=0; (b) output equals previous +1 mod 16 when enabled and dir_cont=0; (c) output equals previous -1 mod 16 when enabled and dir_cont=1; (d) output never X/Z after reset.
REQ-025 When CONTADOR_16_ASSERTIONS_EN is undefined, no assertion code SHALL be compiled and functional behaviour SHALL be identical.

Verification
REQ-026 Assert reset=0 for 10 ns mid-cycle -> contagem_out = 4'h0 before the next clk edge.
REQ-027 Release reset, enable_contador=1, dir_cont=0, run 20 edges -> 1,2,…,F,0,1,2,3,4 (wraps F->0).
REQ-028 From a value of 4, set enable_contador=0 for 3 edges -> contagem_out stays 4'h4.
REQ-029 Reset to 0, enable_contador=1, dir_cont=1, run 20 edges -> F,E,…,1,0,F,E,D,C (wraps 0->F).
REQ-030 Toggle dir_cont at value 7 while enabled -> next edge gives 6 (up->down) or 8 (down->up), no hold cycle.
REQ-031 Assert reset between edges during counting at value A -> immediate 4'h0; after release, the count restarts from 0.
